// File: rtl/seven_segment_pkg.sv
// Shared constants and glyph decode for the seven-segment display controller.
// Segment order is bit0=a .. bit6=g, active-low.
package seven_segment_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low glyphs for 0-9, A, b, C, d, E, F.
    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        SRC_MANUAL = 1'b0,
        SRC_AUTO   = 1'b1
    } src_state_e;

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        return SEG_GLYPH[nibble];
    endfunction

endpackage

// File: rtl/seven_segment_digit.sv
// Combinational decode of one nibble to an active-low 7-segment glyph,
// with a blank override.
module seven_segment_digit
    import seven_segment_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_BLANK : seg_decode(nibble);

endmodule

// File: rtl/seven_segment_display_ctrl.sv
// Multi-source hex display controller: manual or auto-rotating source select,
// tick-paced refresh, freeze and leading-zero blanking. Digit blinking is built
// in only when SEVEN_SEG_BLINK_EN is defined.
module seven_segment_display_ctrl
    import seven_segment_pkg::*;
#(
    parameter  int DIGITS      = 6,
    parameter  int SOURCES     = 4,
    parameter  int TICK_CYCLES = 50000,
    parameter  int DWELL_TICKS = 2000,
    parameter  int BLINK_TICKS = 250,
    localparam int SEL_W       = $clog2(SOURCES)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [SOURCES*DIGITS*4-1:0] src_data,
    input  logic [SEL_W-1:0]            src_sel,
    input  logic                        auto_en,
    input  logic                        freeze,
    input  logic                        lz_blank,
`ifdef SEVEN_SEG_BLINK_EN
    input  logic [DIGITS-1:0]           blink_mask,
`endif
    output logic [DIGITS*7-1:0]         hex,
    output logic [SEL_W-1:0]            cur_src,
    output logic                        upd_strobe
);

    localparam int WORD_W = DIGITS * 4;
    localparam int PRE_W  = $clog2(TICK_CYCLES);
    localparam int DWL_W  = $clog2(DWELL_TICKS + 1);
    localparam logic [SEL_W:0] SRC_LIM = (SEL_W + 1)'(SOURCES);

    logic [PRE_W-1:0]   presc;
    logic               tick;
    logic               load;
    logic [WORD_W-1:0]  word;
    logic [WORD_W-1:0]  disp_q;
    logic               loaded;
    src_state_e         state;
    logic [DWL_W-1:0]   dwell;
    logic               sel_ok;
    logic [DIGITS-1:0]  lz_mask;
    logic [DIGITS-1:0]  blink_blank;
    logic [DIGITS*7-1:0] seg_next;

    assign tick   = (presc == PRE_W'(TICK_CYCLES - 1));
    assign load   = tick && !freeze;
    assign word   = src_data[cur_src*WORD_W +: WORD_W];
    assign sel_ok = ({1'b0, src_sel} < SRC_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // loaded keeps the display blank from reset until the first real load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q     <= '0;
            loaded     <= 1'b0;
            upd_strobe <= 1'b0;
        end else begin
            upd_strobe <= load && (word != disp_q);
            if (load) begin
                disp_q <= word;
                loaded <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SRC_MANUAL;
            cur_src <= '0;
            dwell   <= '0;
        end else begin
            state <= auto_en ? SRC_AUTO : SRC_MANUAL;
            if (!freeze) begin
                case (state)
                    SRC_MANUAL: begin
                        if (auto_en) begin
                            dwell <= '0;
                        end else if (sel_ok) begin
                            cur_src <= src_sel;
                        end
                    end
                    SRC_AUTO: begin
                        if (!auto_en) begin
                            if (sel_ok) begin
                                cur_src <= src_sel;
                            end
                        end else if (tick) begin
                            if (dwell == DWL_W'(DWELL_TICKS - 1)) begin
                                dwell   <= '0;
                                cur_src <= (cur_src == SEL_W'(SOURCES - 1)) ? '0 : cur_src + 1'b1;
                            end else begin
                                dwell <= dwell + 1'b1;
                            end
                        end
                    end
                    default: begin
                        dwell <= '0;
                    end
                endcase
            end
        end
    end

`ifdef SEVEN_SEG_BLINK_EN
    localparam int BLK_W = $clog2(BLINK_TICKS + 1);

    logic [BLK_W-1:0] blink_cnt;
    logic             phase;

    // Phase keeps running through freeze so frozen digits still blink.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (tick) begin
            if (blink_cnt == BLK_W'(BLINK_TICKS - 1)) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign blink_blank = phase ? blink_mask : '0;
`else
    assign blink_blank = '0;
`endif

    // NOTE: blocking '=' is right here: zero_run carries the scan from the top
    // digit down within one evaluation; defaults first keep this free of latches.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            zero_run   = zero_run && (disp_q[d*4 +: 4] == 4'h0);
            lz_mask[d] = lz_blank && zero_run && (d != 0);
        end
    end

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        seven_segment_digit u_digit (
            .nibble (disp_q[d*4 +: 4]),
            .blank  (!loaded || lz_mask[d] || blink_blank[d]),
            .seg    (seg_next[d*7 +: 7])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex <= '1;
        end else begin
            hex <= seg_next;
        end
    end

endmodule
